// File: rtl/tick_gen.sv
// Clock-enable time base for the digital clock: scan tick, run/hold/fast seconds
// tick, adjust-mode blink level and sub-second position, all on a single clock.
module tick_gen #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int FAST_MS  = 100,
  parameter int BLINK_MS = 500,
  localparam int MSW     = (SCAN_HZ > 1) ? $clog2(SCAN_HZ) : 1
) (
  input  logic           CP,
  input  logic           _CR,
  input  logic           run,
  input  logic           fast,
  input  logic           resync,
  output logic           tick_scan,
  output logic           tick_sec,
  output logic           blink,
  output logic [MSW-1:0] ms_count
);

  localparam int PRE_DIV = CLK_HZ / SCAN_HZ;
  localparam int PW      = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int FW      = (FAST_MS > 1) ? $clog2(FAST_MS) : 1;
  localparam int BW      = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  localparam logic [PW-1:0]  PRE_LAST   = PW'(PRE_DIV - 1);
  localparam logic [MSW-1:0] MS_LAST    = MSW'(SCAN_HZ - 1);
  localparam logic [FW-1:0]  FAST_LAST  = FW'(FAST_MS - 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_MS - 1);

  // Bad parameter sets are rejected at elaboration rather than silently mis-dividing.
  if (SCAN_HZ < 1 || CLK_HZ % SCAN_HZ != 0) begin : g_bad_div
    $fatal(1, "tick_gen: CLK_HZ must be a multiple of SCAN_HZ");
  end
  if (PRE_DIV < 2) begin : g_bad_pre
    $fatal(1, "tick_gen: CLK_HZ/SCAN_HZ must be at least 2");
  end
  if (FAST_MS < 1 || FAST_MS > SCAN_HZ) begin : g_bad_fast
    $fatal(1, "tick_gen: FAST_MS must be in 1..SCAN_HZ");
  end
  if (BLINK_MS < 1) begin : g_bad_blink
    $fatal(1, "tick_gen: BLINK_MS must be at least 1");
  end

  logic [PW-1:0] pre_cnt;
  logic [FW-1:0] fast_cnt;
  logic [BW-1:0] blink_cnt;
  logic          fast_q;

  logic s, adv, ms_hit, fast_hit, blink_hit;

  assign s         = (pre_cnt == PRE_LAST);
  assign adv       = s && run;
  assign ms_hit    = (ms_count == MS_LAST);
  assign fast_hit  = (fast_cnt == FAST_LAST);
  assign blink_hit = (blink_cnt == BLINK_LAST);

  always_ff @(posedge CP) begin
    if (_CR || resync) begin
      pre_cnt   <= '0;
      ms_count  <= '0;
      fast_cnt  <= '0;
      blink_cnt <= '0;
      blink     <= 1'b1;
      tick_scan <= 1'b0;
      tick_sec  <= 1'b0;
      fast_q    <= fast;
    end else begin
      pre_cnt   <= s ? '0 : pre_cnt + 1'b1;
      tick_scan <= s;
      // The mode present on the strobe edge decides which counter ends the second.
      tick_sec  <= adv && (fast ? fast_hit : ms_hit);
      fast_q    <= fast;

      if (adv)
        ms_count <= ms_hit ? '0 : ms_count + 1'b1;

      if (fast != fast_q)
        fast_cnt <= '0;
      else if (adv)
        fast_cnt <= fast_hit ? '0 : fast_cnt + 1'b1;

      // Blink ignores run so digits keep flashing while time is held for adjust.
      if (s) begin
        blink_cnt <= blink_hit ? '0 : blink_cnt + 1'b1;
        if (blink_hit)
          blink <= ~blink;
      end
    end
  end

endmodule
